// File: rtl/fetch_queue.sv
// Instruction-fetch stage: issues synchronous reads to instruction memory and
// buffers fetched {pc, instr} pairs for decode, with branch flush and halt stop.
module fetch_queue #(
  parameter int              XLEN     = 16,
  parameter int              DEPTH    = 4,
  parameter int              INC      = 2,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter logic [3:0]      HLT_OP   = 4'hF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            branch,
  input  logic [XLEN-1:0] pc_branch,
  output logic            imem_rd_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_inc,
  output logic            halted
);

  localparam int              PW         = $clog2(DEPTH);
  localparam int              CW         = PW + 1;
  localparam logic [CW:0]     DEPTH_W    = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] INC_W      = XLEN'(INC);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~(XLEN'(1));

  logic [XLEN-1:0] r_pc;
  logic            r_inflight;
  logic [XLEN-1:0] r_inflight_pc;
  logic            r_halt_seen;
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [XLEN-1:0] r_q_pc    [DEPTH];
  logic [XLEN-1:0] r_q_instr [DEPTH];

  logic [CW:0]     w_pending;
  logic            w_issue;
  logic            w_capture;
  logic            w_deq;
  logic            w_is_hlt;

  // Credit rule: occupied entries plus the in-flight response must leave room.
  assign w_pending = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue   = rst & ~branch & ~r_halt_seen & (w_pending < DEPTH_W);
  assign w_capture = r_inflight & ~branch & ~r_halt_seen;
  assign w_is_hlt  = (imem_data[XLEN-1 -: 4] == HLT_OP);
  assign w_deq     = out_valid & out_ready;

  assign imem_rd_en = w_issue;
  assign imem_addr  = r_pc;

  assign out_valid  = rst & (r_count != '0);
  assign out_pc     = r_q_pc[r_rd_ptr];
  assign out_instr  = r_q_instr[r_rd_ptr];
  assign out_pc_inc = out_pc + INC_W;
  assign halted     = rst & r_halt_seen & (r_count == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_halt_seen   <= 1'b0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
    end else if (branch) begin
      r_pc        <= pc_branch & ALIGN_MASK;
      r_inflight  <= 1'b0;
      r_halt_seen <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
    end else begin
      if (w_issue) begin
        r_pc          <= r_pc + INC_W;
        r_inflight    <= 1'b1;
        r_inflight_pc <= r_pc;
      end else begin
        r_inflight <= 1'b0;
      end

      if (w_capture) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
        if (w_is_hlt) r_halt_seen <= 1'b1;
      end

      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);

      case ({w_capture, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: queue storage has no reset; entries are only visible through the
  // pointers and count, which are reset, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (rst && w_capture) begin
      r_q_pc[r_wr_ptr]    <= r_inflight_pc;
      r_q_instr[r_wr_ptr] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run,
// all checked against a stream-level model of which PCs decode should receive.
module tb_fetch_queue;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        branch;
  logic [15:0] pc_branch;
  logic        out_ready;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = '0;
  logic        out_valid;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pc_inc;
  logic        halted;

  logic        wq_rd_en;
  logic [15:0] wq_addr;
  logic [15:0] wq_data = '0;
  logic        wq_valid;
  logic [15:0] wq_instr;
  logic [15:0] wq_pc;
  logic [15:0] wq_pc_inc;
  logic        wq_halted;

  fetch_queue dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_branch(pc_branch),
    .imem_rd_en(imem_rd_en), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .out_pc_inc(out_pc_inc), .halted(halted)
  );

  fetch_queue #(.RESET_PC(16'hFFFC)) u_wrap (
    .clk(clk), .rst(rst), .branch(1'b0), .pc_branch(16'h0000),
    .imem_rd_en(wq_rd_en), .imem_addr(wq_addr), .imem_data(wq_data),
    .out_valid(wq_valid), .out_ready(1'b1), .out_instr(wq_instr),
    .out_pc(wq_pc), .out_pc_inc(wq_pc_inc), .halted(wq_halted)
  );

  int tests = 0;
  int fails = 0;

  bit          halt_en   = 1'b0;
  logic [15:0] halt_addr = '0;

  // Memory image: word at address a is a/2, except an optional HLT word.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (halt_en && a == halt_addr) return 16'hF000;
    return {1'b0, a[15:1]};
  endfunction

  always @(posedge clk) if (imem_rd_en) imem_data <= mem_word(imem_addr);
  always @(posedge clk) if (wq_rd_en)   wq_data   <= mem_word(wq_addr);

  // Stream model: the next PC decode must see, whether a HLT was consumed,
  // and how many cycles have passed since the last accepted redirect.
  logic [15:0] exp_pc    = '0;
  logic [15:0] br_target = '0;
  bit          hlt_del   = 1'b0;
  int          since_br  = 99;
  int          deliv_cnt = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_check();
    if (!rst) begin
      check("rst_valid", 16'(out_valid), 16'h0);
      check("rst_halted", 16'(halted), 16'h0);
      check("rst_rd_en", 16'(imem_rd_en), 16'h0);
      exp_pc   = 16'h0000;
      hlt_del  = 1'b0;
      since_br = 99;
    end else begin
      check("halted", 16'(halted), 16'(hlt_del));
      if (hlt_del) begin
        check("halt_valid", 16'(out_valid), 16'h0);
        check("halt_rd_en", 16'(imem_rd_en), 16'h0);
      end
      if (since_br == 1 || since_br == 2) check("br_bubble", 16'(out_valid), 16'h0);
      if (since_br == 1 && !branch) begin
        check("br_rd_en", 16'(imem_rd_en), 16'h1);
        check("br_addr", imem_addr, br_target);
      end
      if (out_valid && out_ready) begin
        check("head_pc", out_pc, exp_pc);
        check("head_instr", out_instr, mem_word(exp_pc));
        check("head_pc_inc", out_pc_inc, exp_pc + 16'd2);
        deliv_cnt++;
        if (halt_en && exp_pc == halt_addr) hlt_del = 1'b1;
        exp_pc = exp_pc + 16'd2;
      end
      if (branch) begin
        exp_pc    = pc_branch & 16'hFFFE;
        br_target = exp_pc;
        hlt_del   = 1'b0;
        since_br  = 1;
      end else if (since_br < 99) begin
        since_br++;
      end
    end
  endtask

  task automatic run_cycle();
    model_check();
    @(posedge clk);
    #2;
  endtask

  task automatic step();
    #1;
    run_cycle();
  endtask

  int rd_cnt;
  int d0;

  initial begin
    rst = 1'b0; branch = 1'b0; pc_branch = '0; out_ready = 1'b1;

    // Reset then free-running stream; the wrap instance runs alongside.
    step(); step();
    rst = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      check("stream_valid", 16'(out_valid), 16'(k >= 2));
      if (k == 2) begin
        check("wrap_valid", 16'(wq_valid), 16'h1);
        check("wrap_pc0", wq_pc, 16'hFFFC);
        check("wrap_instr0", wq_instr, 16'h7FFE);
        check("wrap_halted", 16'(wq_halted), 16'h0);
      end
      if (k == 3) begin
        check("wrap_pc1", wq_pc, 16'hFFFE);
        check("wrap_pc_inc1", wq_pc_inc, 16'h0000);
      end
      if (k == 4) check("wrap_pc2", wq_pc, 16'h0000);
      run_cycle();
    end

    // Backpressure: queue fills to DEPTH, issue stops, then drains in order.
    rst = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    rd_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (imem_rd_en) rd_cnt++;
      run_cycle();
    end
    #1;
    check("bp_reads", 16'(rd_cnt), 16'd4);
    check("bp_rd_en", 16'(imem_rd_en), 16'h0);
    check("bp_valid", 16'(out_valid), 16'h1);
    out_ready = 1'b1;
    d0 = deliv_cnt;
    #1;
    run_cycle();
    #1;
    check("bp_credit", 16'(imem_rd_en), 16'h1);
    repeat (7) step();
    check("bp_delivered", 16'(deliv_cnt - d0), 16'd8);

    // Redirect with three entries queued and one read in flight.
    rst = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b1;
    repeat (4) step();
    #1;
    check("redir_pre_valid", 16'(out_valid), 16'h1);
    check("redir_pre_rd_en", 16'(imem_rd_en), 16'h0);
    branch = 1'b1; pc_branch = 16'h0041;
    #1;
    run_cycle();
    branch = 1'b0; out_ready = 1'b1;
    #1;
    check("redir_addr", imem_addr, 16'h0040);
    check("redir_valid0", 16'(out_valid), 16'h0);
    run_cycle();
    step();
    #1;
    check("redir_head_valid", 16'(out_valid), 16'h1);
    check("redir_head_pc", out_pc, 16'h0040);
    run_cycle();

    // Branch in the same cycle as a dequeue.
    repeat (3) step();
    #1;
    check("bd_valid", 16'(out_valid), 16'h1);
    branch = 1'b1; pc_branch = 16'h0080;
    #1;
    run_cycle();
    branch = 1'b0;
    #1;
    check("bd_empty", 16'(out_valid), 16'h0);
    run_cycle();
    step();
    #1;
    check("bd_head_valid", 16'(out_valid), 16'h1);
    check("bd_head_pc", out_pc, 16'h0080);
    run_cycle();

    // Halt at address 6, then a redirect resumes fetching.
    rst = 1'b0; out_ready = 1'b1;
    step();
    halt_en = 1'b1; halt_addr = 16'h0006;
    step();
    rst = 1'b1;
    d0 = deliv_cnt;
    repeat (14) step();
    #1;
    check("hlt_count", 16'(deliv_cnt - d0), 16'd4);
    check("hlt_halted", 16'(halted), 16'h1);
    check("hlt_rd_en", 16'(imem_rd_en), 16'h0);
    branch = 1'b1; pc_branch = 16'h0000;
    #1;
    run_cycle();
    branch = 1'b0;
    #1;
    check("hlt_clear", 16'(halted), 16'h0);
    check("hlt_resume", 16'(imem_rd_en), 16'h1);
    run_cycle();
    repeat (3) step();

    // Randomized traffic: backpressure, redirects, occasional reset, halts at 0x100.
    rst = 1'b0;
    step();
    halt_addr = 16'h0100;
    step();
    rst = 1'b1;
    for (int k = 0; k < 600; k++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      branch    = ($urandom_range(0, 15) == 0);
      pc_branch = 16'($urandom_range(0, 511));
      rst       = ($urandom_range(0, 199) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
